// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: transfer-phase states and the byte-lane
// merge used when a masked write lands in a register.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE               = 2'd0,
    PROCESS            = 2'd1,
    WAIT_FOR_PHASE_END = 2'd2
  } state_t;

  localparam int MERGE_WIDTH = 64;

  // laneBits is the lane select expanded to one bit per data bit; mask marks writable bits.
  function automatic logic [MERGE_WIDTH-1:0] merge_lanes(
    input logic [MERGE_WIDTH-1:0] oldVal,
    input logic [MERGE_WIDTH-1:0] newVal,
    input logic [MERGE_WIDTH-1:0] laneBits,
    input logic [MERGE_WIDTH-1:0] mask
  );
    return (oldVal & ~(laneBits & mask)) | (newVal & laneBits & mask);
  endfunction

endpackage

// File: rtl/wb_slave_regfile_if.sv
// Wishbone B4 classic bus bundle; signal names follow the slave's point of view.
interface wb_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) ();

  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic                  we_i;
  logic                  stb_i;
  logic                  cyc_i;
  logic                  ack_o;
  logic                  err_o;

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_slave_regfile.sv
// Generic Wishbone control/status register file: masked byte-lane writes, lane-gated
// reads, error termination on out-of-range addresses, parallel export of every register.
module wb_slave_regfile
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int NUM_REGS   = 8,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] WRITE_MASK  = '1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  wb_if.slave                            wb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int OFS_BITS  = $clog2(SEL_WIDTH);
  localparam int IDX_BITS  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int IDXF_W    = ADDR_WIDTH - OFS_BITS;

  state_t r_state;
  state_t w_nextState;

  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [NUM_REGS-1:0]   r_pulse;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                   w_cycStb;
  logic [IDXF_W-1:0]      w_idxFull;
  logic [IDX_BITS-1:0]    w_idx;
  logic                   w_valid;
  logic [DATA_WIDTH-1:0]  w_bitSel;
  logic [DATA_WIDTH-1:0]  w_curReg;
  logic [DATA_WIDTH-1:0]  w_curMask;
  logic [MERGE_WIDTH-1:0] w_mergeFull;
  logic [DATA_WIDTH-1:0]  w_merged;
  logic                   w_ackNext;
  logic                   w_errNext;
  logic [DATA_WIDTH-1:0]  w_datNext;
  logic [NUM_REGS-1:0]    w_pulseNext;
  logic                   w_regWrEn;
  logic                   w_unusedAdr;
  logic                   w_unused;

  assign w_cycStb  = wb.cyc_i & wb.stb_i;
  assign w_idxFull = wb.adr_i[ADDR_WIDTH-1:OFS_BITS];
  assign w_valid   = w_idxFull < IDXF_W'(NUM_REGS);
  assign w_idx     = w_idxFull[IDX_BITS-1:0];

  if (OFS_BITS > 0) begin : g_adrLow
    assign w_unusedAdr = ^wb.adr_i[OFS_BITS-1:0];
  end else begin : g_noAdrLow
    assign w_unusedAdr = 1'b0;
  end

  for (genvar l = 0; l < SEL_WIDTH; l++) begin : g_lane
    assign w_bitSel[l*GRANULE +: GRANULE] = {GRANULE{wb.sel_i[l]}};
  end

  always_comb begin
    w_curReg  = '0;
    w_curMask = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_idx == IDX_BITS'(k)) begin
        w_curReg  = r_regs[k];
        w_curMask = WRITE_MASK[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_mergeFull = merge_lanes(MERGE_WIDTH'(w_curReg), MERGE_WIDTH'(wb.dat_i),
                                   MERGE_WIDTH'(w_bitSel), MERGE_WIDTH'(w_curMask));
  assign w_merged    = w_mergeFull[DATA_WIDTH-1:0];
  assign w_unused    = ^{w_unusedAdr, w_mergeFull};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:               if (w_cycStb) w_nextState = PROCESS;
      PROCESS:            w_nextState = w_cycStb ? WAIT_FOR_PHASE_END : IDLE;
      WAIT_FOR_PHASE_END: if (!w_cycStb) w_nextState = IDLE;
      default:            w_nextState = IDLE;
    endcase
  end

  // ack/err/dat_o hold through the wait phase; the write pulse is rebuilt every cycle.
  always_comb begin
    w_ackNext   = r_ack;
    w_errNext   = r_err;
    w_datNext   = r_dat;
    w_pulseNext = '0;
    w_regWrEn   = 1'b0;
    case (r_state)
      PROCESS: begin
        if (w_cycStb) begin
          if (w_valid) begin
            w_ackNext = 1'b1;
            w_errNext = 1'b0;
            if (wb.we_i) begin
              w_datNext = '0;
              w_regWrEn = |wb.sel_i;
              if (|wb.sel_i) w_pulseNext = NUM_REGS'(1) << w_idx;
            end else begin
              w_datNext = w_curReg & w_bitSel;
            end
          end else begin
            w_ackNext = 1'b0;
            w_errNext = 1'b1;
            w_datNext = '0;
          end
        end
      end
      WAIT_FOR_PHASE_END: begin
        if (!w_cycStb) begin
          w_ackNext = 1'b0;
          w_errNext = 1'b0;
        end
      end
      default: begin
        w_ackNext = 1'b0;
        w_errNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_pulse <= '0;
    end else begin
      r_ack   <= w_ackNext;
      r_err   <= w_errNext;
      r_dat   <= w_datNext;
      r_pulse <= w_pulseNext;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VALUE[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_regWrEn && (w_idx == IDX_BITS'(k))) r_regs[k] <= w_merged;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_export
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
  end

  assign wr_pulse_o = r_pulse;
  assign wb.dat_o   = r_dat;
  assign wb.ack_o   = w_cycStb & r_ack;
  assign wb.err_o   = w_cycStb & r_err;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Randomized Wishbone transfers against a word-array model of the register file,
// with literal spot checks for the documented scenarios.
module tb_wb_slave_regfile;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int NR = 8;

  localparam logic [NR*DW-1:0] RST_VAL = {32'hFFFFFFFF, 32'h80000001, 32'h00000000, 32'h0F0F0F0F,
                                          32'h12345678, 32'h00000000, 32'h00000000, 32'hCAFE0000};
  localparam logic [NR*DW-1:0] WR_MASK = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFF00FF00, 32'hFFFFFFFF,
                                          32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

  logic [31:0] resetWord [NR] = '{32'hCAFE0000, 32'h00000000, 32'h00000000, 32'h12345678,
                                  32'h0F0F0F0F, 32'h00000000, 32'h80000001, 32'hFFFFFFFF};
  logic [31:0] maskWord  [NR] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hFF00FF00, 32'hFFFFFFFF, 32'hFFFFFFFF};

  logic clk;
  logic rst;
  logic [NR*DW-1:0] regsO;
  logic [NR-1:0]    pulseO;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  wb_slave_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .NUM_REGS(NR),
    .RESET_VALUE(RST_VAL), .WRITE_MASK(WR_MASK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb(bus), .regs_o(regsO), .wr_pulse_o(pulseO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [NR];
  logic        expAck = 1'b0;
  logic        expErr = 1'b0;
  logic [7:0]  expPulse = 8'h00;
  logic [31:0] expDat = 32'h0;
  bit          datValid = 1'b0;
  bit          checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [255:0] flatModel();
    logic [255:0] r;
    for (int k = 0; k < NR; k++) r[k*32 +: 32] = model[k];
    return r;
  endfunction

  task automatic resetModel();
    for (int k = 0; k < NR; k++) model[k] = resetWord[k];
    expAck = 1'b0; expErr = 1'b0; expPulse = 8'h00; expDat = 32'h0; datValid = 1'b1;
  endtask

  // What the slave must show right after the terminating edge of a transfer.
  task automatic modelTransfer(input logic we, input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int idx;
    idx = int'(adr) / 4;
    if (idx >= NR) begin
      expErr = 1'b1; expAck = 1'b0; expDat = 32'h0; datValid = 1'b1; expPulse = 8'h00;
    end else begin
      expAck = 1'b1; expErr = 1'b0;
      if (we) begin
        for (int lane = 0; lane < 4; lane++)
          if (sel[lane])
            for (int b = 0; b < 8; b++)
              if (maskWord[idx][lane*8+b]) model[idx][lane*8+b] = dat[lane*8+b];
        expPulse = (sel != 4'h0) ? 8'(1 << idx) : 8'h00;
        datValid = 1'b0;
      end else begin
        expDat = 32'h0;
        for (int lane = 0; lane < 4; lane++)
          if (sel[lane]) expDat[lane*8 +: 8] = model[idx][lane*8 +: 8];
        datValid = 1'b1;
        expPulse = 8'h00;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("regs_o", 256'(regsO), flatModel());
      checkOutput("wr_pulse_o", 256'(pulseO), 256'(expPulse));
      checkOutput("ack_o", 256'(bus.ack_o), 256'(expAck));
      checkOutput("err_o", 256'(bus.err_o), 256'(expErr));
      checkOutput("ack_err_both", 256'(bus.ack_o & bus.err_o), 256'(0));
      if (datValid) checkOutput("dat_o", 256'(bus.dat_o), 256'(expDat));
    end
  end

  // Called and returns at posedge+1; mode 0 normal, 1 strobe dropped in PROCESS, 2 reset in WAIT.
  task automatic applyStimulus(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input int hold, input bit keepCyc, input int mode);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i = adr; bus.dat_i = dat; bus.sel_i = sel;
    @(posedge clk); #1;
    if (mode == 1) begin
      bus.stb_i = 1'b0; bus.cyc_i = keepCyc;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    modelTransfer(we, adr, dat, sel);
    if (mode == 2) begin
      #1;
      rst = 1'b1;
      resetModel();
      #1;
      checkOutput("rst_ack_async", 256'(bus.ack_o), 256'(0));
      checkOutput("rst_regs_async", 256'(regsO), 256'(RST_VAL));
      bus.stb_i = 1'b0; bus.cyc_i = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      expPulse = 8'h00;
    end
    bus.stb_i = 1'b0; bus.cyc_i = keepCyc;
    expAck = 1'b0; expErr = 1'b0;
    @(posedge clk); #1;
    expPulse = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [255:0] snap;
    rst = 1'b1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0;
    resetModel();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkEn = 1'b1;
    checkOutput("pin_reset_regs", 256'(regsO), 256'(RST_VAL));
    checkOutput("pin_reset_dat", 256'(bus.dat_o), 256'(0));

    for (int k = 0; k < NR; k++) applyStimulus(1'b0, 16'(k*4), 32'h0, 4'hF, 1, 1'b0, 0);
    checkOutput("pin_read_reg7", 256'(bus.dat_o), 256'(32'hFFFFFFFF));

    applyStimulus(1'b1, 16'h0004, 32'hDEADBEEF, 4'b0101, 1, 1'b0, 0);
    checkOutput("pin_reg1_lanes", 256'(regsO[63:32]), 256'(32'h00AD00EF));

    applyStimulus(1'b1, 16'h0008, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 0);
    checkOutput("pin_reg2_mask", 256'(regsO[95:64]), 256'(32'h0000FFFF));
    applyStimulus(1'b0, 16'h0008, 32'h0, 4'hF, 0, 1'b0, 0);
    checkOutput("pin_reg2_readback", 256'(bus.dat_o), 256'(32'h0000FFFF));

    snap = 256'(regsO);
    applyStimulus(1'b0, 16'h0020, 32'h0, 4'hF, 2, 1'b0, 0);
    checkOutput("pin_err_dat", 256'(bus.dat_o), 256'(0));
    applyStimulus(1'b1, 16'h0020, 32'h5555AAAA, 4'hF, 0, 1'b0, 0);
    checkOutput("pin_err_nochange", 256'(regsO), snap);

    applyStimulus(1'b1, 16'h0000, 32'h11111111, 4'hF, 0, 1'b0, 1);
    checkOutput("pin_abort_nowrite", 256'(regsO[31:0]), 256'(32'hCAFE0000));
    idleCycles(1);
    applyStimulus(1'b1, 16'h0018, 32'h77777777, 4'hF, 0, 1'b0, 2);
    idleCycles(1);

    applyStimulus(1'b0, 16'h000C, 32'h0, 4'hF, 0, 1'b1, 0);
    checkOutput("pin_rmw_read", 256'(bus.dat_o), 256'(32'h12345678));
    applyStimulus(1'b1, 16'h000C, 32'h000000FF, 4'b0001, 0, 1'b0, 0);
    checkOutput("pin_rmw_write", 256'(regsO[127:96]), 256'(32'h123456FF));

    applyStimulus(1'b1, 16'h0010, 32'hABCDEF01, 4'h0, 1, 1'b0, 0);
    checkOutput("pin_sel0_nochange", 256'(regsO[159:128]), 256'(32'h0F0F0F0F));

    for (int t = 0; t < 200; t++) begin
      logic        we;
      logic [15:0] adr;
      logic [3:0]  sel;
      int          r, m, mode;
      bit          keepCyc;
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r < 8)       adr = 16'((r * 4) + int'($urandom_range(0, 3)));
      else if (r == 8) adr = 16'(32 + int'($urandom_range(0, 15)));
      else             adr = 16'($urandom);
      sel = 4'($urandom_range(0, 15));
      keepCyc = 1'($urandom_range(0, 1));
      m = int'($urandom_range(0, 19));
      mode = (m == 0) ? 1 : (m == 1) ? 2 : 0;
      applyStimulus(we, adr, $urandom, sel, int'($urandom_range(0, 2)), keepCyc, mode);
      if (!keepCyc || mode != 0) idleCycles(int'($urandom_range(0, 2)));
    end

    idleCycles(2);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
